dcache_wt: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache for the pipelined RV32I core.
- Sits between the memory stage and the backing data RAM. The memory stage drives its load/store request here instead of to the RAM directly.
- Stall is driven into the hazard unit. It freezes fetch through memory and bubbles writeback while a miss or store is in flight.
- Load data returned here is already sign/zero-extended for the writeback mux.

---
 rtl/dcache_wt_if.sv | 40 ++++
 rtl/dcache_wt.sv | 184 ++++++++++++++++++
 tb/tb_dcache_wt.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_wt_if.sv
// dcache_wt_if: groups the data cache's two buses into one bundle.
//   Core side : ReqM/WeM/AddrM/WDataM/funct3M (request), RDataM/Stall (response)
//   RAM side  : mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb (request),
//               mem_rdata/mem_ready (response)
// Handshake: a backing-RAM transfer is in flight while mem_req=1; it completes
// on the rising edge where mem_ready=1. mem_ready without mem_req means nothing.
// The core holds its request fields stable for as long as Stall=1.
// Modports:
//   master - memory stage + backing RAM (drive requests and RAM responses)
//   slave  - the cache itself
interface dcache_wt_if;
    logic        ReqM;
    logic        WeM;
    logic [31:0] AddrM;
    logic [31:0] WDataM;
    logic [2:0]  funct3M;
    logic [31:0] RDataM;
    logic        Stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output ReqM, WeM, AddrM, WDataM, funct3M,
        input  RDataM, Stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );

    modport slave (
        input  ReqM, WeM, AddrM, WDataM, funct3M,
        output RDataM, Stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );
endinterface

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache with
// one-word lines, between the RV32I memory stage and the backing data RAM.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   bus         dcache_wt_if.slave (core request/response + backing RAM bus)
//   hit_cnt     load hits, wrapping
//   miss_cnt    load misses, wrapping
//   o_dbg_state current FSM state (IDLE=0, RD_MISS=1, WRITE=2, DONE=3)
module dcache_wt #(
    parameter int SETS = 256
) (
    input  logic        clk,
    input  logic        rst,
    dcache_wt_if.slave  bus,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic [1:0]  o_dbg_state
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = 30 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            r_state;
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [31:0]       r_data [SETS];
    logic [31:0]       r_hit_cnt;
    logic [31:0]       r_miss_cnt;
    logic              r_mem_req;
    logic              r_mem_we;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_is_load;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_ext;
    logic [3:0]         w_wstrb;
    logic [31:0]        w_wdata;
    logic [31:0]        w_merged;
    logic               w_stall;
    logic               w_rdata_valid;

    // Combinational lookup on the live memory-stage address.
    assign w_index   = bus.AddrM[2+INDEX_W-1:2];
    assign w_tag     = bus.AddrM[31:2+INDEX_W];
    assign w_hit     = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_is_load = bus.ReqM && !bus.WeM;
    assign w_word    = r_data[w_index];

    // Load extraction: funct3[1:0] picks size, funct3[2] selects zero-extension.
    always_comb begin
        w_byte     = w_word[{bus.AddrM[1:0], 3'b000} +: 8];
        w_half     = bus.AddrM[1] ? w_word[31:16] : w_word[15:0];
        w_load_ext = w_word;
        case (bus.funct3M[1:0])
            2'b00:   w_load_ext = {{24{~bus.funct3M[2] & w_byte[7]}}, w_byte};
            2'b01:   w_load_ext = {{16{~bus.funct3M[2] & w_half[15]}}, w_half};
            default: w_load_ext = w_word;
        endcase
    end

    // Store lanes: narrow data is replicated so the strobe alone picks the lane.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = bus.WDataM;
        case (bus.funct3M[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << bus.AddrM[1:0];
                w_wdata = {4{bus.WDataM[7:0]}};
            end
            2'b01: begin
                w_wstrb = bus.AddrM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.WDataM[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = bus.WDataM;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_merged[8*i +: 8] = w_wstrb[i] ? w_wdata[8*i +: 8] : w_word[8*i +: 8];
        end
    end

    // Stall must rise in the same cycle a miss/store is seen, so it is decoded
    // from state plus the live lookup. Reset forces it low asynchronously.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            IDLE:           w_stall = bus.ReqM && (bus.WeM || !w_hit);
            RD_MISS, WRITE: w_stall = 1'b1;
            DONE:           w_stall = 1'b0;
            default:        w_stall = 1'b0;
        endcase
    end

    assign w_rdata_valid = w_is_load && (((r_state == IDLE) && w_hit) || (r_state == DONE));

    assign bus.Stall     = !rst && w_stall;
    assign bus.RDataM    = (!rst && w_rdata_valid) ? w_load_ext : 32'd0;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = {bus.AddrM[31:2], 2'b00};
    assign bus.mem_wdata = w_wdata;
    assign bus.mem_wstrb = w_wstrb;
    assign hit_cnt       = r_hit_cnt;
    assign miss_cnt      = r_miss_cnt;
    assign o_dbg_state   = r_state;

    // Tag/data arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (r_state == RD_MISS && bus.mem_ready) begin
            r_data[w_index] <= bus.mem_rdata;
            r_tag[w_index]  <= w_tag;
        end else if (r_state == WRITE && bus.mem_ready && w_hit) begin
            r_data[w_index] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_valid    <= '0;
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.ReqM) begin
                        if (bus.WeM) begin
                            r_state   <= WRITE;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= 1'b1;
                        end else if (w_hit) begin
                            r_hit_cnt <= r_hit_cnt + 32'd1;
                        end else begin
                            r_miss_cnt <= r_miss_cnt + 32'd1;
                            r_state    <= RD_MISS;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                        end
                    end
                end
                RD_MISS: begin
                    if (bus.mem_ready) begin
                        r_valid[w_index] <= 1'b1;
                        r_state          <= DONE;
                        r_mem_req        <= 1'b0;
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        r_state   <= DONE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_wt.sv
module tb_dcache_wt;
  localparam int SETS  = 256;

  logic clk;
  logic rst;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [1:0]  dbg_state;

  dcache_wt_if bus();

  dcache_wt #(.SETS(SETS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  logic [31:0] ram [int unsigned];
  bit          m_valid [SETS];
  int unsigned m_tag   [SETS];
  logic [31:0] m_data  [SETS];
  logic [31:0] m_hits;
  logic [31:0] m_misses;
  logic [31:0] exp_q [$];

  int total;
  int bad;
  int ram_wait;
  int req_cnt;

  function automatic logic [31:0] ram_rd(input int unsigned wa);
    if (ram.exists(wa)) return ram[wa];
    return (wa * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
    logic [31:0] v;
    int shift;
    bit signed_ld;
    signed_ld = (f3 < 4);
    case (f3 % 4)
      0: begin
        shift = (addr % 4) * 8;
        v = (word >> shift) & 32'hFF;
        if (signed_ld && v >= 128) v = v + 32'hFFFFFF00;
      end
      1: begin
        shift = ((addr & 2) != 0) ? 16 : 0;
        v = (word >> shift) & 32'hFFFF;
        if (signed_ld && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) m_valid[i] = 0;
    m_hits = 0;
    m_misses = 0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- backing RAM responder ----------------
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (req_cnt == ram_wait) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = ram_rd(bus.mem_addr >> 2);
      end else begin
        bus.mem_ready = 1'b0;
      end
      req_cnt++;
    end else begin
      bus.mem_ready = 1'b0;
      req_cnt = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] f3, input int waitc);
    int unsigned wa, idx, tg;
    bit hit, seen_req, done;
    int exp_stall, stalls;
    logic [31:0] word, exp_wd, cur, exp_rd;
    logic [3:0] exp_strb;
    wa  = addr >> 2;
    idx = wa % SETS;
    tg  = wa / SETS;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_strb = 4'hF;
    exp_wd = wd;
    if (!we) begin
      if (hit) begin
        word = m_data[idx];
        m_hits++;
        exp_stall = 0;
      end else begin
        word = ram_rd(wa);
        m_data[idx] = word;
        m_tag[idx] = tg;
        m_valid[idx] = 1;
        m_misses++;
        exp_stall = 2 + waitc;
      end
      exp_q.push_back(load_value(word, addr, f3));
    end else begin
      case (f3 % 4)
        0: begin
          exp_strb = 4'(1 << (addr % 4));
          exp_wd = (wd & 32'hFF) * 32'h01010101;
        end
        1: begin
          exp_strb = ((addr & 2) != 0) ? 4'b1100 : 4'b0011;
          exp_wd = (wd & 32'hFFFF) * 32'h00010001;
        end
        default: begin
          exp_strb = 4'b1111;
          exp_wd = wd;
        end
      endcase
      cur = ram_rd(wa);
      for (int i = 0; i < 4; i++) if (exp_strb[i]) cur[8*i +: 8] = exp_wd[8*i +: 8];
      ram[wa] = cur;
      if (hit) begin
        cur = m_data[idx];
        for (int i = 0; i < 4; i++) if (exp_strb[i]) cur[8*i +: 8] = exp_wd[8*i +: 8];
        m_data[idx] = cur;
      end
      exp_stall = 2 + waitc;
    end

    ram_wait = waitc;
    @(posedge clk);
    #1;
    bus.ReqM = 1'b1;
    bus.WeM = we;
    bus.AddrM = addr;
    bus.WDataM = wd;
    bus.funct3M = f3;

    stalls = 0;
    seen_req = 0;
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (bus.Stall) begin
        stalls++;
        check("rdata_during_stall", bus.RDataM, 32'd0);
        if (bus.mem_req && !seen_req) begin
          seen_req = 1;
          check("mem_we", 32'(bus.mem_we), 32'(we));
          check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
          if (we) begin
            check("mem_wstrb", 32'(bus.mem_wstrb), 32'(exp_strb));
            check("mem_wdata", bus.mem_wdata, exp_wd);
          end
        end
      end else begin
        done = 1;
      end
    end
    check("stall_bounded", 32'(done), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
    if (exp_stall > 0) check("mem_req_seen", 32'(seen_req), 32'd1);
    if (!we) begin
      exp_rd = exp_q.pop_front();
      check("rdata", bus.RDataM, exp_rd);
    end else begin
      check("rdata_store", bus.RDataM, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.ReqM = 1'b0;
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] ld_f3 [5];

  initial begin
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
    ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    total = 0;
    bad = 0;
    ram_wait = 0;
    req_cnt = 0;
    model_reset();
    rst = 1'b1;
    bus.ReqM = 1'b0;
    bus.WeM = 1'b0;
    bus.AddrM = 32'd0;
    bus.WDataM = 32'd0;
    bus.funct3M = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 32'(bus.Stall), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_rdata", bus.RDataM, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b0;

    // 1: fill then hit
    ram[32'h100 >> 2] = 32'hDEADBEEF;
    do_access(0, 32'h100, 0, 3'b010, 0);
    do_access(0, 32'h100, 0, 3'b010, 0);
    // 2: byte store into cached line, then assorted loads
    do_access(1, 32'h101, 32'h55, 3'b000, 0);
    do_access(0, 32'h100, 0, 3'b010, 0);
    do_access(0, 32'h101, 0, 3'b000, 0);
    do_access(0, 32'h103, 0, 3'b100, 0);
    do_access(0, 32'h103, 0, 3'b000, 0);
    // 3: uncached store with wait states, no allocate
    do_access(1, 32'h200, 32'h12345678, 3'b010, 3);
    do_access(0, 32'h200, 0, 3'b010, 0);
    // 4: aliasing on the same index
    do_access(0, 32'h100, 0, 3'b010, 0);
    do_access(0, 32'h500, 0, 3'b010, 1);
    do_access(0, 32'h100, 0, 3'b010, 0);

    // 5: reset while a fill is outstanding
    ram_wait = 1000;
    @(posedge clk);
    #1;
    bus.ReqM = 1'b1;
    bus.WeM = 1'b0;
    bus.AddrM = 32'h900;
    bus.funct3M = 3'b010;
    repeat (3) @(negedge clk);
    check("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
    check("pre_rst_stall", 32'(bus.Stall), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("mid_rst_stall", 32'(bus.Stall), 32'd0);
    check("mid_rst_hit_cnt", hit_cnt, 32'd0);
    check("mid_rst_miss_cnt", miss_cnt, 32'd0);
    bus.ReqM = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    do_access(0, 32'h100, 0, 3'b010, 0);

    // 6: halfword sign/zero extension
    do_access(1, 32'h100, 32'h80017FFF, 3'b010, 0);
    do_access(0, 32'h102, 0, 3'b001, 0);
    do_access(0, 32'h102, 0, 3'b101, 2);
    do_access(0, 32'h100, 0, 3'b001, 0);

    // random traffic over a small address pool to mix hits, misses, aliases
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      bit w;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      w = ($urandom_range(0, 99) < 40);
      if (w) do_access(1, a, $urandom, 3'($urandom_range(0, 2)), $urandom_range(0, 3));
      else   do_access(0, a, 0, ld_f3[$urandom_range(0, 4)], $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
